input_arbiter: RTL and testbench

INPUT_ARBITER -- requirements
Module: input_arbiter

---
 rtl/input_arbiter_pkg.sv | 12 +
 rtl/input_arbiter_if.sv | 33 +++
 rtl/rr_picker.sv | 30 +++
 rtl/input_arbiter.sv | 138 +++++++++++++
 tb/tb_input_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_arbiter_pkg.sv
// Shared types and constants for the frame-locking round-robin input arbiter.
package input_arbiter_pkg;

   localparam int FRAME_CNT_W = 16;
   localparam int IDLE_CNT_W  = 16;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/input_arbiter_if.sv
// Requester-side handshake and beat bus of the input arbiter.
interface input_arbiter_if
   import input_arbiter_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4
);
   localparam int SRC_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                         req_en_in;
   logic [NUM_REQ-1:0]                         valid_in;
   logic [NUM_REQ-1:0]                         eof_in;
   logic [NUM_REQ-1:0][N-1:0][DATA_WIDTH-1:0]  vector_in;
   logic [NUM_REQ-1:0]                         ready_out;
   logic                                       valid_out;
   logic                                       eof_out;
   logic [N-1:0][DATA_WIDTH-1:0]               vector_out;
   logic [SRC_W-1:0]                           src_id_out;
   logic                                       abort_out;
   logic [FRAME_CNT_W-1:0]                     frame_cnt_out;

   modport master (
      output req_en_in, valid_in, eof_in, vector_in,
      input  ready_out, valid_out, eof_out, vector_out, src_id_out, abort_out, frame_cnt_out
   );

   modport slave (
      input  req_en_in, valid_in, eof_in, vector_in,
      output ready_out, valid_out, eof_out, vector_out, src_id_out, abort_out, frame_cnt_out
   );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_found
);

   logic [IDX_W-1:0] w_cand_idx;

   always_comb begin
      o_grant    = '0;
      o_idx      = '0;
      o_found    = 1'b0;
      w_cand_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cand_idx = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
         if (!o_found && i_req[w_cand_idx]) begin
            o_found             = 1'b1;
            o_idx               = w_cand_idx;
            o_grant[w_cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_arbiter.sv
// Frame-locking round-robin arbiter: one requester owns the output until eof or idle timeout.
//   state     | meaning
//   ST_IDLE   | no frame open; grant goes to round-robin winner among enabled, valid requesters
//   ST_LOCKED | frame open on r_owner; only the owner is accepted, idle cycles counted
module input_arbiter
   import input_arbiter_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input_arbiter_if.slave  arb_if
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t                   r_state, w_state_nxt;
   logic [IDX_W-1:0]             r_rr_ptr, w_rr_ptr_nxt;
   logic [IDX_W-1:0]             r_owner, w_owner_nxt;
   logic [IDLE_CNT_W-1:0]        r_idle_cnt, w_idle_cnt_nxt;

   logic [NUM_REQ-1:0]           w_cand, w_pick_grant, w_ready;
   logic [IDX_W-1:0]             w_pick_idx, w_acc_idx;
   logic                         w_pick_found, w_accept, w_acc_eof, w_timeout;

   logic                         r_valid_out, r_eof_out, r_abort_out;
   logic [N-1:0][DATA_WIDTH-1:0] r_vector_out;
   logic [IDX_W-1:0]             r_src_id;
   logic [FRAME_CNT_W-1:0]       r_frame_cnt;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
   endfunction

   assign w_cand = arb_if.valid_in & arb_if.req_en_in;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
      .i_req   (w_cand),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_owner_nxt    = r_owner;
      w_idle_cnt_nxt = r_idle_cnt;
      w_ready        = '0;
      w_acc_idx      = r_owner;
      w_timeout      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready        = w_pick_grant;
            w_acc_idx      = w_pick_idx;
            w_idle_cnt_nxt = '0;
            // the winner is valid by construction, so a found winner is an accepted beat
            if (w_pick_found) begin
               if (arb_if.eof_in[w_pick_idx]) begin
                  w_rr_ptr_nxt = next_idx(w_pick_idx);
               end else begin
                  w_state_nxt = ST_LOCKED;
                  w_owner_nxt = w_pick_idx;
               end
            end
         end
         ST_LOCKED: begin
            w_ready[r_owner] = 1'b1;
            if (arb_if.valid_in[r_owner]) begin
               w_idle_cnt_nxt = '0;
               if (arb_if.eof_in[r_owner]) begin
                  w_state_nxt  = ST_IDLE;
                  w_rr_ptr_nxt = next_idx(r_owner);
               end
            end else if (r_idle_cnt == IDLE_CNT_W'(TIMEOUT - 1)) begin
               w_state_nxt    = ST_IDLE;
               w_rr_ptr_nxt   = next_idx(r_owner);
               w_idle_cnt_nxt = '0;
               w_timeout      = 1'b1;
            end else begin
               w_idle_cnt_nxt = r_idle_cnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (!rst_n_in) w_ready = '0;
   end

   assign w_accept  = |(w_ready & arb_if.valid_in);
   assign w_acc_eof = arb_if.eof_in[w_acc_idx];

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_idle_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_owner    <= w_owner_nxt;
         r_idle_cnt <= w_idle_cnt_nxt;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_valid_out  <= 1'b0;
         r_eof_out    <= 1'b0;
         r_abort_out  <= 1'b0;
         r_vector_out <= '0;
         r_src_id     <= '0;
         r_frame_cnt  <= '0;
      end else begin
         r_valid_out <= w_accept;
         r_eof_out   <= w_accept & w_acc_eof;
         r_abort_out <= w_timeout;
         if (w_accept) begin
            r_vector_out <= arb_if.vector_in[w_acc_idx];
            r_src_id     <= w_acc_idx;
         end
         if (w_accept && w_acc_eof) r_frame_cnt <= r_frame_cnt + 1'b1;
      end
   end

   assign arb_if.ready_out     = w_ready;
   assign arb_if.valid_out     = r_valid_out;
   assign arb_if.eof_out       = r_eof_out;
   assign arb_if.abort_out     = r_abort_out;
   assign arb_if.vector_out    = r_vector_out;
   assign arb_if.src_id_out    = r_src_id;
   assign arb_if.frame_cnt_out = r_frame_cnt;

endmodule

// File: tb/tb_input_arbiter.sv
// Bench for input_arbiter: per-cycle reference model plus directed frame scenarios and random traffic.
module tb_input_arbiter;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int TO = 64;
   localparam int VW = N * DW;
   localparam int IW = $clog2(NR);

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;
   always #5 clk_in = ~clk_in;

   input_arbiter_if #(.N(N), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

   input_arbiter #(.N(N), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .arb_if   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: frame ownership described as plain integers
   bit              m_ok = 1'b0;
   bit              m_locked;
   int              m_owner, m_ptr, m_idle;
   logic            e_valid, e_eof, e_abort;
   logic [VW-1:0]   e_vec;
   int              e_src;
   logic [15:0]     e_cnt;
   logic [NR-1:0]   acc_seen = '0;
   logic [NR-1:0]   e_ready;
   int              win, r;

   always @(negedge clk_in) begin
      if (m_ok) begin
         chk("valid_out",     VW'(bus.valid_out),     VW'(e_valid));
         chk("eof_out",       VW'(bus.eof_out),       VW'(e_eof));
         chk("abort_out",     VW'(bus.abort_out),     VW'(e_abort));
         chk("vector_out",    bus.vector_out,         e_vec);
         chk("src_id_out",    VW'(bus.src_id_out),    VW'(e_src[IW-1:0]));
         chk("frame_cnt_out", VW'(bus.frame_cnt_out), VW'(e_cnt));
      end
      e_ready = '0;
      if (rst_n_in) begin
         if (m_locked) begin
            e_ready[m_owner] = 1'b1;
         end else begin
            win = -1;
            for (int i = 0; i < NR; i++) begin
               r = (m_ptr + i) % NR;
               if (win < 0 && bus.valid_in[r] && bus.req_en_in[r]) win = r;
            end
            if (win >= 0) e_ready[win] = 1'b1;
         end
      end
      chk("ready_out", VW'(bus.ready_out), VW'(e_ready));
      acc_seen = bus.valid_in & bus.ready_out;

      if (!rst_n_in) begin
         m_ok = 1'b1; m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_idle = 0;
         e_valid = 1'b0; e_eof = 1'b0; e_abort = 1'b0; e_vec = '0; e_src = 0; e_cnt = '0;
      end else begin
         e_valid = 1'b0; e_eof = 1'b0; e_abort = 1'b0;
         win = -1;
         for (int i = 0; i < NR; i++) if (e_ready[i] && bus.valid_in[i]) win = i;
         if (win >= 0) begin
            e_valid = 1'b1;
            e_eof   = bus.eof_in[win];
            e_vec   = bus.vector_in[win];
            e_src   = win;
            m_idle  = 0;
            if (e_eof) begin
               e_cnt    = e_cnt + 16'd1;
               m_locked = 1'b0;
               m_ptr    = (win + 1) % NR;
            end else begin
               m_locked = 1'b1;
               m_owner  = win;
            end
         end else if (m_locked) begin
            m_idle++;
            if (m_idle == TO) begin
               m_locked = 1'b0;
               m_ptr    = (m_owner + 1) % NR;
               m_idle   = 0;
               e_abort  = 1'b1;
            end
         end
      end
   end

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_in();
      bus.valid_in  = '0;
      bus.eof_in    = '0;
      bus.req_en_in = '1;
   endtask

   task automatic rand_data();
      for (int i = 0; i < NR; i++) bus.vector_in[i] = rand_vec();
   endtask

   task automatic do_reset();
      rst_n_in     = 1'b0;
      bus.valid_in = '1;
      bus.eof_in   = '0;
      #1;
      chk("rst_ready_zero", VW'(bus.ready_out), '0);
      step();
      step();
      chk("rst_valid_out", VW'(bus.valid_out), '0);
      chk("rst_vector_out", bus.vector_out, '0);
      chk("rst_frame_cnt", VW'(bus.frame_cnt_out), '0);
      chk("rst_abort", VW'(bus.abort_out), '0);
      rst_n_in = 1'b1;
      idle_in();
   endtask

   initial begin
      logic [VW-1:0] beat [3];
      logic [NR-1:0] ph, prev;
      int            q[$];
      int            exp_ord[5] = '{0, 1, 2, 3, 0};
      int            n, total, cyc, quiet;
      bit            seen;

      idle_in();
      bus.vector_in = '0;
      do_reset();

      // single 3-beat frame from requester 0
      for (int b = 0; b < 3; b++) beat[b] = rand_vec();
      for (int b = 0; b < 3; b++) begin
         bus.valid_in     = 4'b0001;
         bus.eof_in       = (b == 2) ? 4'b0001 : 4'b0000;
         bus.vector_in[0] = beat[b];
         step();
         chk("t038_valid", VW'(bus.valid_out), VW'(1'b1));
         chk("t038_src", VW'(bus.src_id_out), '0);
         chk("t038_eof", VW'(bus.eof_out), VW'(b == 2));
         chk("t038_vec", bus.vector_out, beat[b]);
      end
      idle_in();
      chk("t038_cnt", VW'(bus.frame_cnt_out), VW'(16'd1));
      step();
      chk("t038_idle_valid", VW'(bus.valid_out), '0);

      // all requesters streaming 2-beat frames
      do_reset();
      ph = '0;
      for (int c = 0; c < 20; c++) begin
         bus.valid_in = '1;
         bus.eof_in   = ph;
         rand_data();
         step();
         chk("t039_onehot", VW'($onehot(acc_seen)), VW'(1'b1));
         ph = ph ^ acc_seen;
         if (bus.valid_out && bus.eof_out) q.push_back(int'(bus.src_id_out));
      end
      idle_in();
      for (int i = 0; i < 5; i++) chk("t039_order", VW'((i < q.size()) ? q[i] : -1), VW'(exp_ord[i]));

      // requester 2 stalls mid-frame until timeout
      do_reset();
      bus.valid_in = 4'b0100;
      rand_data();
      step();
      chk("t040_accept", VW'(acc_seen), VW'(4'b0100));
      idle_in();
      n = 1;
      seen = 1'b0;
      while (!seen && n < 200) begin
         if (bus.abort_out) seen = 1'b1;
         else begin
            step();
            n++;
         end
      end
      chk("t040_abort_delay", VW'(n), VW'(65));
      chk("t040_cnt", VW'(bus.frame_cnt_out), '0);
      bus.valid_in = 4'b1011;
      bus.eof_in   = 4'b1011;
      step();
      chk("t040_abort_pulse", VW'(bus.abort_out), '0);
      chk("t040_next_src", VW'(bus.src_id_out), VW'(3));
      idle_in();

      // only enabled requesters 1 and 3 compete
      bus.req_en_in = 4'b1010;
      bus.valid_in  = '1;
      bus.eof_in    = '1;
      prev = '0;
      for (int c = 0; c < 8; c++) begin
         rand_data();
         step();
         chk("t041_grant", VW'(acc_seen == 4'b0010 || acc_seen == 4'b1000), VW'(1'b1));
         if (c > 0) chk("t041_alternate", VW'(acc_seen != prev), VW'(1'b1));
         prev = acc_seen;
      end
      idle_in();

      // reset during beat 2 of a frame from requester 1
      do_reset();
      bus.valid_in = 4'b0010;
      rand_data();
      step();
      rand_data();
      rst_n_in = 1'b0;
      #1;
      chk("t042_ready_rst", VW'(bus.ready_out), '0);
      step();
      chk("t042_valid", VW'(bus.valid_out), '0);
      chk("t042_vec", bus.vector_out, '0);
      chk("t042_src", VW'(bus.src_id_out), '0);
      rst_n_in     = 1'b1;
      bus.valid_in = 4'b1100;
      bus.eof_in   = 4'b1100;
      step();
      chk("t042_abort", VW'(bus.abort_out), '0);
      chk("t042_src_next", VW'(bus.src_id_out), VW'(2));
      idle_in();

      // random traffic with occasional silent stretches and resets
      do_reset();
      quiet = 0;
      for (int c = 0; c < 3000; c++) begin
         if (quiet == 0 && $urandom_range(399) == 0) quiet = 80;
         for (int i = 0; i < NR; i++) begin
            bus.valid_in[i]  = (quiet == 0) && ($urandom_range(3) != 0);
            bus.req_en_in[i] = ($urandom_range(6) != 0);
            bus.eof_in[i]    = ($urandom_range(2) == 0);
         end
         if (quiet > 0) quiet--;
         rand_data();
         rst_n_in = ($urandom_range(299) != 0);
         step();
      end
      rst_n_in = 1'b1;
      idle_in();

      // frame counter wrap with single-beat frames
      do_reset();
      bus.valid_in = 4'b0011;
      bus.eof_in   = 4'b0011;
      total = 0;
      cyc   = 0;
      while (total < 70000 && cyc < 70100) begin
         step();
         total += $countones(acc_seen);
         cyc++;
      end
      chk("t043_frames", VW'(total), VW'(70000));
      chk("t043_wrap", VW'(bus.frame_cnt_out), VW'(16'd4464));
      idle_in();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
